// File: rtl/br_table_walker_pkg.sv
// Shared definitions for the br_table label walker: FSM encodings, error codes
// and the byte-lane helper used by the LEB128 decoder.
package br_table_walker_pkg;

  localparam logic [1:0] BRT_IDLE  = 2'd0;
  localparam logic [1:0] BRT_COUNT = 2'd1;
  localparam logic [1:0] BRT_ENTRY = 2'd2;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'd0,
    ERR_MEM   = 2'd1,
    ERR_LEB   = 2'd2,
    ERR_COUNT = 2'd3
  } brt_err_e;

  localparam int LEB_WINDOW_BITS = 40;

  // Byte 0 of the window sits in the most-significant lane.
  function automatic logic [7:0] leb_byte(input logic [39:0] win, input int idx);
    return win[39-8*idx -: 8];
  endfunction

endpackage

// File: rtl/br_table_walker_leb128_u32_dec.sv
// Combinational unsigned LEB128 decoder for a 32-bit immediate held in a
// 5-byte window; reports the encoded length and whether the encoding is malformed.
module leb128_u32_dec
  import br_table_walker_pkg::*;
(
  input  logic [39:0] i_window,
  output logic [31:0] o_value,
  output logic [2:0]  o_len,
  output logic        o_malformed
);

  logic [7:0] w_byte;
  logic       w_stop;

  // After the loop w_byte holds byte 4, which carries the overflow checks.
  always_comb begin
    o_value     = '0;
    o_len       = 3'd5;
    o_malformed = 1'b0;
    w_stop      = 1'b0;
    w_byte      = '0;
    for (int i = 0; i < 5; i++) begin
      w_byte = leb_byte(i_window, i);
      if (!w_stop) begin
        o_value = o_value | ({25'd0, w_byte[6:0]} << (7 * i));
        if (!w_byte[7]) begin
          o_len  = 3'(i + 1);
          w_stop = 1'b1;
        end
      end
    end
    if (!w_stop) begin
      o_malformed = 1'b1;
    end else if (o_len == 3'd5 && w_byte[6:4] != 3'd0) begin
      o_malformed = 1'b1;
    end
  end

endmodule

// File: rtl/br_table_walker.sv
// br_table helper: walks the LEB128 label vector in genrom and returns the
// selected relative depth, consuming one LEB128 per cycle while it owns the ROM port.
module br_table_walker
  import br_table_walker_pkg::*;
#(
  parameter int MEM_DEPTH   = 6,
  parameter int MEM_EXTRA   = 4,
  parameter int MAX_TARGETS = 1024
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic                          i_start,
  input  logic [MEM_DEPTH:0]            i_pc,
  input  logic [31:0]                   i_index,
  output logic [MEM_DEPTH:0]            o_mem_addr,
  output logic [MEM_EXTRA-1:0]          o_mem_extra,
  input  logic [(2**MEM_EXTRA)*8-1:0]   i_mem_data,
  input  logic                          i_mem_error,
  output logic                          o_busy,
  output logic                          o_done,
  output logic [31:0]                   o_depth,
  output logic                          o_err,
  output logic [1:0]                    o_err_code
);

  localparam int AW = MEM_DEPTH + 1;
  localparam int DW = (2**MEM_EXTRA) * 8;

  logic [1:0]    r_state;
  logic [AW-1:0] r_cur_addr;
  logic [31:0]   r_index;
  logic [31:0]   r_sel;
  logic [31:0]   r_k;
  logic [31:0]   r_depth;
  logic          r_done;
  logic          r_err;
  logic [1:0]    r_err_code;

  logic [LEB_WINDOW_BITS-1:0] w_window;
  logic [31:0]   w_value;
  logic [2:0]    w_len;
  logic          w_malformed;
  logic [AW-1:0] w_next_addr;
  logic          w_fail;
  logic [1:0]    w_fail_code;
  logic          w_unused_lanes;

  assign w_window       = i_mem_data[DW-1 -: LEB_WINDOW_BITS];
  assign w_unused_lanes = ^i_mem_data[DW-LEB_WINDOW_BITS-1:0];

  leb128_u32_dec u_dec (
    .i_window    (w_window),
    .o_value     (w_value),
    .o_len       (w_len),
    .o_malformed (w_malformed)
  );

  // The next fetch address is formed from the current decode so a new LEB128
  // is ready every cycle; wraparound is left to genrom's bounds check.
  assign w_next_addr = r_cur_addr + AW'(w_len);
  assign o_mem_addr  = (r_state == BRT_IDLE) ? i_pc : w_next_addr;
  assign o_mem_extra = MEM_EXTRA'(4);

  always_comb begin
    w_fail      = 1'b0;
    w_fail_code = ERR_NONE;
    if (i_mem_error) begin
      w_fail      = 1'b1;
      w_fail_code = ERR_MEM;
    end else if (w_malformed) begin
      w_fail      = 1'b1;
      w_fail_code = ERR_LEB;
    end else if (r_state == BRT_COUNT && w_value > 32'(MAX_TARGETS)) begin
      w_fail      = 1'b1;
      w_fail_code = ERR_COUNT;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= BRT_IDLE;
      r_cur_addr <= '0;
      r_index    <= '0;
      r_sel      <= '0;
      r_k        <= '0;
      r_depth    <= '0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_err_code <= ERR_NONE;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        BRT_IDLE: begin
          if (i_start) begin
            r_cur_addr <= i_pc;
            r_index    <= i_index;
            r_err_code <= ERR_NONE;
            r_state    <= BRT_COUNT;
          end
        end
        BRT_COUNT: begin
          if (w_fail) begin
            r_err      <= 1'b1;
            r_err_code <= w_fail_code;
            r_state    <= BRT_IDLE;
          end else begin
            // An out-of-range index selects the default entry, stored after the count entries.
            r_sel      <= (r_index < w_value) ? r_index : w_value;
            r_k        <= '0;
            r_cur_addr <= w_next_addr;
            r_state    <= BRT_ENTRY;
          end
        end
        BRT_ENTRY: begin
          if (w_fail) begin
            r_err      <= 1'b1;
            r_err_code <= w_fail_code;
            r_state    <= BRT_IDLE;
          end else if (r_k == r_sel) begin
            r_depth <= w_value;
            r_done  <= 1'b1;
            r_state <= BRT_IDLE;
          end else begin
            r_k        <= r_k + 32'd1;
            r_cur_addr <= w_next_addr;
          end
        end
        default: r_state <= BRT_IDLE;
      endcase
    end
  end

  assign o_busy     = (r_state != BRT_IDLE);
  assign o_done     = r_done;
  assign o_err      = r_err;
  assign o_depth    = r_depth;
  assign o_err_code = r_err_code;

endmodule

// File: tb/tb_br_table_walker.sv
// Directed bench for br_table_walker: a byte-array genrom and a table-walk
// reference model, checked cycle by cycle against the DUT.
module tb_br_table_walker;

  localparam int MEM_DEPTH = 6;
  localparam int MEM_EXTRA = 4;
  localparam int AW        = MEM_DEPTH + 1;
  localparam int DW        = (2**MEM_EXTRA) * 8;
  localparam int ROM_SIZE  = 2**AW;

  logic              i_clk = 1'b0;
  logic              i_reset;
  logic              i_start;
  logic [AW-1:0]     i_pc;
  logic [31:0]       i_index;
  logic [AW-1:0]     o_mem_addr;
  logic [MEM_EXTRA-1:0] o_mem_extra;
  logic [DW-1:0]     memData;
  logic              memError;
  logic              o_busy;
  logic              o_done;
  logic [31:0]       o_depth;
  logic              o_err;
  logic [1:0]        o_err_code;

  br_table_walker #(.MEM_DEPTH(MEM_DEPTH), .MEM_EXTRA(MEM_EXTRA), .MAX_TARGETS(1024)) dut (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_start     (i_start),
    .i_pc        (i_pc),
    .i_index     (i_index),
    .o_mem_addr  (o_mem_addr),
    .o_mem_extra (o_mem_extra),
    .i_mem_data  (memData),
    .i_mem_error (memError),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_depth     (o_depth),
    .o_err       (o_err),
    .o_err_code  (o_err_code)
  );

  always #5 i_clk = ~i_clk;

  // genrom stand-in: registered address, 5-byte fetch checked against romBound.
  logic [7:0]    rom [ROM_SIZE];
  int            romBound = ROM_SIZE;
  logic [AW-1:0] romAddr = '0;

  always @(posedge i_clk) romAddr <= o_mem_addr;

  always_comb begin
    memData = '0;
    for (int j = 0; j < 2**MEM_EXTRA; j++)
      memData[DW-1-8*j -: 8] = rom[(int'(romAddr) + j) % ROM_SIZE];
    memError = (int'(romAddr) + 5 > romBound);
  end

  int          checks = 0;
  int          errors = 0;
  logic [31:0] heldDepth = 32'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clearRom();
    for (int j = 0; j < ROM_SIZE; j++) rom[j] = 8'h00;
  endtask

  task automatic loadTable(input int base, input logic [63:0] bytesIn, input int n);
    for (int j = 0; j < n; j++) rom[(base + j) % ROM_SIZE] = bytesIn[8*(n-1-j) +: 8];
  endtask

  // Sequential byte-at-a-time LEB128 parse straight from the ROM image.
  task automatic decodeLeb(input int a, output logic [31:0] val, output int len, output bit bad);
    longint acc;
    logic [7:0] b;
    acc = 0;
    bad = 1'b1;
    len = 5;
    for (int j = 0; j < 5; j++) begin
      b = rom[(a + j) % ROM_SIZE];
      acc = acc | (longint'(b[6:0]) << (7 * j));
      if (!b[7]) begin
        len = j + 1;
        bad = (j == 4) && (b[6:4] != 3'd0);
        break;
      end
    end
    val = acc[31:0];
  endtask

  // kind: 0 = done, 1 = err; edgeNo counts from the start-sampling edge.
  task automatic modelWalk(input int pc, input logic [31:0] idx, output int kind,
                           output logic [31:0] depth, output int code, output int edgeNo);
    int a;
    int len;
    bit bad;
    logic [31:0] v;
    longint sel;
    a = pc;
    kind = 1;
    depth = heldDepth;
    code = 0;
    edgeNo = 1;
    if (a + 5 > romBound) begin code = 1; return; end
    decodeLeb(a, v, len, bad);
    if (bad) begin code = 2; return; end
    if (v > 32'd1024) begin code = 3; return; end
    sel = (longint'(idx) < longint'(v)) ? longint'(idx) : longint'(v);
    for (longint k = 0; k <= sel; k++) begin
      a = (a + len) % ROM_SIZE;
      edgeNo = 2 + int'(k);
      if (a + 5 > romBound) begin code = 1; return; end
      decodeLeb(a, v, len, bad);
      if (bad) begin code = 2; return; end
      if (k == sel) begin
        kind = 0;
        depth = v;
        return;
      end
    end
  endtask

  task automatic applyStimulus(input int pc, input logic [31:0] idx);
    @(negedge i_clk);
    i_pc = AW'(pc);
    i_index = idx;
    i_start = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    i_start = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input int e, input int kind,
                             input logic [31:0] depth, input int code, input int edgeNo);
    bit pulse;
    pulse = (e == edgeNo);
    check({tag, ".done"}, 32'(o_done), 32'(pulse && kind == 0));
    check({tag, ".err"}, 32'(o_err), 32'(pulse && kind == 1));
    check({tag, ".busy"}, 32'(o_busy), 32'(e < edgeNo));
    if (e >= edgeNo) check({tag, ".depth"}, o_depth, depth);
    if (pulse && kind == 1) check({tag, ".errCode"}, 32'(o_err_code), 32'(code));
  endtask

  task automatic runCase(input string tag, input int pc, input logic [31:0] idx,
                         input int litKind, input logic [31:0] litDepth, input int litCode,
                         input int litEdge, input bit pokeStart);
    int mKind, mCode, mEdge;
    logic [31:0] mDepth;
    modelWalk(pc, idx, mKind, mDepth, mCode, mEdge);
    check({tag, ".model.kind"}, 32'(mKind), 32'(litKind));
    check({tag, ".model.depth"}, mDepth, litDepth);
    check({tag, ".model.code"}, 32'(mCode), 32'(litCode));
    check({tag, ".model.edge"}, 32'(mEdge), 32'(litEdge));
    applyStimulus(pc, idx);
    for (int e = 0; e <= mEdge + 2; e++) begin
      if (pokeStart) i_start = (e == 1);
      checkOutput(tag, e, mKind, mDepth, mCode, mEdge);
      @(negedge i_clk);
    end
    i_start = 1'b0;
    if (mKind == 0) heldDepth = mDepth;
  endtask

  initial begin
    i_reset = 1'b1;
    i_start = 1'b0;
    i_pc = 7'd5;
    i_index = 32'd0;
    clearRom();
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    check("reset.busy", 32'(o_busy), 32'd0);
    check("reset.done", 32'(o_done), 32'd0);
    check("reset.err", 32'(o_err), 32'd0);
    check("reset.depth", o_depth, 32'd0);
    check("reset.errCode", 32'(o_err_code), 32'd0);
    check("reset.memAddr", 32'(o_mem_addr), 32'd5);
    check("memExtra", 32'(o_mem_extra), 32'd4);
    i_reset = 1'b0;

    loadTable(0, 64'h03_00_01_02_05, 5);
    runCase("idx1", 0, 32'd1, 0, 32'd1, 0, 3, 1'b0);
    runCase("idx7", 0, 32'd7, 0, 32'd5, 0, 5, 1'b1);
    runCase("idxMax", 0, 32'hFFFF_FFFF, 0, 32'd5, 0, 5, 1'b0);
    runCase("idx2", 0, 32'd2, 0, 32'd2, 0, 4, 1'b0);

    clearRom();
    loadTable(0, 64'h00_09, 2);
    runCase("cnt0", 0, 32'd3, 0, 32'd9, 0, 2, 1'b0);

    clearRom();
    loadTable(0, 64'h02_80_01_05_07, 5);
    runCase("leb2", 0, 32'd0, 0, 32'd128, 0, 2, 1'b0);
    runCase("leb2b", 0, 32'd1, 0, 32'd5, 0, 3, 1'b0);

    clearRom();
    loadTable(0, 64'h01_FF_FF_FF_FF_7F, 6);
    runCase("badEntry", 0, 32'd0, 1, 32'd5, 2, 2, 1'b0);

    clearRom();
    loadTable(0, 64'hFF_FF_FF_FF_FF, 5);
    runCase("badCount", 0, 32'd0, 1, 32'd5, 2, 1, 1'b0);

    clearRom();
    loadTable(0, 64'h81_08, 2);
    runCase("cnt1025", 0, 32'd0, 1, 32'd5, 3, 1, 1'b0);

    clearRom();
    loadTable(0, 64'h80_08_04, 3);
    runCase("cnt1024", 0, 32'd0, 0, 32'd4, 0, 2, 1'b0);

    clearRom();
    loadTable(0, 64'h01_8F_FF_FF_FF_0F, 6);
    runCase("leb5", 0, 32'd0, 0, 32'hFFFF_FF8F, 0, 2, 1'b0);

    clearRom();
    loadTable(3, 64'h05_00_00_00_00_00, 6);
    romBound = 10;
    runCase("bound", 3, 32'd4, 1, 32'hFFFF_FF8F, 1, 4, 1'b0);
    romBound = ROM_SIZE;

    clearRom();
    runCase("wrap", 125, 32'd0, 1, 32'hFFFF_FF8F, 1, 1, 1'b0);

    // Reset sampled at edge 2 of a walk that would finish at edge 6.
    clearRom();
    loadTable(0, 64'h05_01_02_03_04_05, 6);
    applyStimulus(0, 32'd4);
    check("midReset.busyE0", 32'(o_busy), 32'd1);
    @(negedge i_clk);
    i_reset = 1'b1;
    @(negedge i_clk);
    check("midReset.busy", 32'(o_busy), 32'd0);
    check("midReset.done", 32'(o_done), 32'd0);
    check("midReset.depth", o_depth, 32'd0);
    i_reset = 1'b0;
    heldDepth = 32'd0;
    for (int c = 0; c < 8; c++) begin
      @(negedge i_clk);
      check("midReset.noDone", 32'(o_done), 32'd0);
      check("midReset.noErr", 32'(o_err), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
